// File: rtl/timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_ctrl_if
//
// Peripheral-bus bundle for the timer controller. The CPU side drives the
// strobes, address and write data; the timer returns registered read data.
//
// Signals:
//   bus_we     write strobe, one cycle per write
//   bus_re     read strobe, one cycle per read
//   bus_addr   byte offset, bits [3:2] select the register
//   bus_wdata  write data
//   bus_rdata  read data, valid the cycle after bus_re
//
// Modports:
//   master  CPU / bus side
//   slave   timer side
// ---------------------------------------------------------------------------
interface timer_ctrl_if;
  logic        bus_we;
  logic        bus_re;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_we,
    output bus_re,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_we,
    input  bus_re,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// Memory-mapped timer. A prescaler produces a one-cycle tick every PRESC+1
// cycles while the timer runs; each tick decrements COUNT. A tick seen with
// COUNT already at zero is an expiry: it sets PEND and either reloads COUNT
// from LOAD (periodic) or stops the timer (one-shot). irq is PEND & IE,
// registered one edge behind the register values.
//
// Register map (byte offset, bits [3:2] decoded):
//   0x0 CTRL  : bit0 EN, bit1 MODE (1 = periodic), bit2 IE,
//               bit3 PEND (write 1 clears), other bits read 0
//   0x4 PRESC : prescale value
//   0x8 LOAD  : reload value
//   0xC COUNT : current count, read-only
//
// Ports:
//   clk    system clock
//   rst_n  synchronous, active-low reset
//   bus    timer_ctrl_if.slave register bus
//   irq    level interrupt request, active-high
//
// Parameter:
//   CNT_W  width of the prescaler, reload and count registers (<= 32);
//          narrower fields are zero-extended on read
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus,
  output logic         irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SEL_CTRL  = 2'd0;
  localparam logic [1:0] SEL_PRESC = 2'd1;
  localparam logic [1:0] SEL_LOAD  = 2'd2;
  localparam logic [1:0] SEL_COUNT = 2'd3;

  state_t state;
  state_t state_next;

  logic             mode;
  logic             ie;
  logic             pend;
  logic             pend_next;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pcnt;

  logic             ctrl_wr;
  logic             presc_wr;
  logic             load_wr;
  logic             ack_wr;

  logic             start;
  logic             stop;
  logic             active;
  logic             tick;
  logic             expire;

  logic [31:0]      rd_mux;

  // Byte-lane bits of the address are not decoded.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.bus_addr[1:0];

  // Register write decode. COUNT is read-only, so its offset has no strobe.
  always_comb begin
    ctrl_wr  = bus.bus_we && (bus.bus_addr[3:2] == SEL_CTRL);
    presc_wr = bus.bus_we && (bus.bus_addr[3:2] == SEL_PRESC);
    load_wr  = bus.bus_we && (bus.bus_addr[3:2] == SEL_LOAD);
    ack_wr   = ctrl_wr && bus.bus_wdata[3];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state. Writing EN=1 while already running is not a restart;
  // a one-shot expiry drops back to IDLE even if the same cycle writes EN=1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (stop || (expire && !mode)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. A stop write freezes the counters on that same edge, so
  // the prescaler only advances on RUN cycles that are not being stopped.
  always_comb begin
    start  = 1'b0;
    stop   = 1'b0;
    active = 1'b0;
    case (state)
      IDLE: start = ctrl_wr && bus.bus_wdata[0];
      RUN: begin
        stop   = ctrl_wr && !bus.bus_wdata[0];
        active = !stop;
      end
      default: ;
    endcase
  end

  // Tick and expiry use the pre-edge PRESC, LOAD and MODE values, so a
  // write landing on the same edge only matters from the next cycle on.
  assign tick   = active && (pcnt == presc);
  assign expire = tick && (count == '0);

  // Expiry wins over a same-cycle acknowledge.
  assign pend_next = expire || (pend && !ack_wr);

  // Prescaler counter. A PRESC write restarts the phase so a smaller
  // value can never be overshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (start || presc_wr) begin
      pcnt <= '0;
    end else if (active) begin
      pcnt <= tick ? '0 : pcnt + CNT_W'(1);
    end
  end

  // Down-counter. A one-shot expiry leaves COUNT at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (tick) begin
      if (expire) begin
        if (mode) count <= load;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode  <= 1'b0;
      ie    <= 1'b0;
      presc <= '0;
      load  <= '0;
    end else begin
      if (ctrl_wr) begin
        mode <= bus.bus_wdata[1];
        ie   <= bus.bus_wdata[2];
      end
      if (presc_wr) presc <= CNT_W'(bus.bus_wdata);
      if (load_wr)  load  <= CNT_W'(bus.bus_wdata);
    end
  end

  // Pending flag and interrupt. irq tracks the registered PEND/IE pair,
  // so it lags them by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      irq  <= 1'b0;
    end else begin
      pend <= pend_next;
      irq  <= pend && ie;
    end
  end

  // Read mux over the pre-edge register values. EN is simply "running".
  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr[3:2])
      SEL_CTRL:  rd_mux = {28'd0, pend, ie, mode, (state == RUN)};
      SEL_PRESC: rd_mux = 32'(presc);
      SEL_LOAD:  rd_mux = 32'(load);
      SEL_COUNT: rd_mux = 32'(count);
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.bus_rdata <= '0;
    end else if (bus.bus_re) begin
      bus.bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//
// Bench for timer_ctrl. A behavioural model tracks the timer in terms of
// elapsed edges since the prescaler phase origin and the remaining count;
// a compare process checks irq and bus_rdata against it after every edge.
// Directed scenarios pin both the DUT and the model to hand-computed values,
// then randomized bus traffic exercises the rest.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  timer_ctrl_if bus_if ();

  timer_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  longint      edge_no  = 0;
  longint      origin   = 0;
  bit          model_ok = 1'b0;
  bit          m_run, m_mode, m_ie, m_pend, m_irq;
  bit [31:0]   m_p, m_l, m_count, m_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluate one edge from the pre-edge state and the bus inputs.
  // The prescaler ticks whenever a whole number of (P+1)-cycle periods has
  // elapsed since the last phase origin (start or PRESC write).
  always @(posedge clk) begin : model
    bit [1:0] sel;
    bit       cw, pw, lw, fired, stopping;
    bit [31:0] wd;
    edge_no++;
    if (!rst_n) begin
      m_run = 0; m_mode = 0; m_ie = 0; m_pend = 0; m_irq = 0;
      m_p = 0; m_l = 0; m_count = 0; m_rdata = 0;
      origin = edge_no;
      model_ok = 1'b1;
    end else begin
      sel = bus_if.bus_addr[3:2];
      wd  = bus_if.bus_wdata;
      cw  = bus_if.bus_we && sel == 2'd0;
      pw  = bus_if.bus_we && sel == 2'd1;
      lw  = bus_if.bus_we && sel == 2'd2;
      if (bus_if.bus_re) begin
        case (sel)
          2'd0: m_rdata = {28'd0, m_pend, m_ie, m_mode, m_run};
          2'd1: m_rdata = m_p;
          2'd2: m_rdata = m_l;
          default: m_rdata = m_count;
        endcase
      end
      m_irq = m_pend && m_ie;
      fired = 0;
      stopping = m_run && cw && !wd[0];
      if (!m_run) begin
        if (cw && wd[0]) begin
          m_run = 1; m_count = m_l; origin = edge_no;
        end
      end else if (stopping) begin
        m_run = 0;
      end else if ((edge_no - origin) % (longint'(m_p) + 1) == 0) begin
        if (m_count == 0) begin
          fired = 1;
          if (m_mode) m_count = m_l;
          else        m_run = 0;
        end else begin
          m_count = m_count - 1;
        end
      end
      if (pw) origin = edge_no;
      m_pend = fired || (m_pend && !(cw && wd[3]));
      if (cw) begin
        m_mode = wd[1];
        m_ie   = wd[2];
      end
      if (pw) m_p = wd;
      if (lw) m_l = wd;
    end
  end

  // Cycle-by-cycle comparison against the model, #1 after each edge.
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      checkOutput("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
      checkOutput("cyc_rdata", bus_if.bus_rdata, m_rdata);
    end
  end

  // One bus cycle: drive at negedge, return just after the sampling edge.
  task automatic applyStimulus(input bit we, input bit re, input bit [3:0] addr,
                               input bit [31:0] wdata);
    @(negedge clk);
    rst_n            = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_re    = re;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n            = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic wr(input bit [3:0] addr, input bit [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic rd(input bit [3:0] addr);
    applyStimulus(1'b0, 1'b1, addr, 32'h0);
  endtask

  // Literal expectations applied to both the DUT and the model.
  task automatic checkRd(input string name, input bit [31:0] exp);
    checkOutput({name, "_dut"}, bus_if.bus_rdata, exp);
    checkOutput({name, "_model"}, m_rdata, exp);
  endtask

  task automatic checkIrq(input string name, input bit exp);
    checkOutput({name, "_dut"}, {31'd0, irq}, {31'd0, exp});
    checkOutput({name, "_model"}, {31'd0, m_irq}, {31'd0, exp});
  endtask

  initial begin
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;

    resetDut();
    resetDut();
    checkIrq("reset_irq", 1'b0);
    checkRd("reset_rdata", 32'h0);

    // Periodic: P=3, L=2, expiry every 12 cycles.
    $display("[TB] periodic timing");
    wr(4'h4, 32'd3);
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h7);
    idle(11);  checkIrq("per_irq_t11", 1'b0);
    idle(1);   checkIrq("per_irq_t12", 1'b0);
    rd(4'h0);  checkRd("per_ctrl_t13", 32'hF); checkIrq("per_irq_t13", 1'b1);
    rd(4'hC);  checkRd("per_count_t14", 32'd2);
    idle(3); rd(4'hC); checkRd("per_count_t18", 32'd1);
    idle(3); rd(4'hC); checkRd("per_count_t22", 32'd0);
    idle(3); rd(4'hC); checkRd("per_count_t26", 32'd2);
    rd(4'h0);  checkRd("per_ctrl_held", 32'hF);

    // One-shot: P=0, L=5, expiry after 6 cycles, then stopped.
    $display("[TB] one-shot");
    resetDut();
    wr(4'h4, 32'd0);
    wr(4'h8, 32'd5);
    wr(4'h0, 32'h5);
    idle(6);   checkIrq("os_irq_t6", 1'b0);
    rd(4'h0);  checkRd("os_ctrl", 32'hC); checkIrq("os_irq_t7", 1'b1);
    rd(4'hC);  checkRd("os_count", 32'd0);
    idle(50);  checkIrq("os_irq_late", 1'b1);
    rd(4'h0);  checkRd("os_ctrl_late", 32'hC);
    rd(4'hC);  checkRd("os_count_late", 32'd0);

    // Acknowledge race: P=0, L=3, expiries at W+4, W+8, ...
    $display("[TB] acknowledge race");
    resetDut();
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h7);
    idle(3);
    wr(4'h0, 32'hF);  checkIrq("ack_same_irq", 1'b0);
    rd(4'h0);         checkRd("ack_same_ctrl", 32'hF); checkIrq("ack_same_irq1", 1'b1);
    idle(3);
    wr(4'h0, 32'hF);  checkIrq("ack_late_irq0", 1'b1);
    idle(1);          checkIrq("ack_late_irq1", 1'b0);
    rd(4'h0);         checkRd("ack_late_ctrl", 32'h7);

    // Mid-run LOAD: P=1, L=4 then L=1 -> expiry at W+10, then W+14.
    $display("[TB] mid-run load change");
    resetDut();
    wr(4'h4, 32'd1);
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h7);
    idle(2);
    wr(4'h8, 32'd1);
    idle(7);          checkIrq("ld_irq_t10", 1'b0);
    idle(1);          checkIrq("ld_irq_t11", 1'b1);
    wr(4'h0, 32'hF);
    idle(1);          checkIrq("ld_irq_t13", 1'b0);
    idle(1);          checkIrq("ld_irq_t14", 1'b0);
    idle(1);          checkIrq("ld_irq_t15", 1'b1);

    // Masking: one-shot with IE=0, then unmask.
    $display("[TB] masking");
    resetDut();
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h1);
    idle(5);          checkIrq("mask_irq0", 1'b0);
    rd(4'h0);         checkRd("mask_ctrl", 32'h8);
    wr(4'h0, 32'h4);  checkIrq("mask_irq_wr", 1'b0);
    idle(1);          checkIrq("mask_irq_on", 1'b1);
    rd(4'h0);         checkRd("mask_ctrl_ie", 32'hC);

    // Reset mid-run.
    $display("[TB] reset mid-run");
    resetDut();
    wr(4'h4, 32'd1);
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h7);
    idle(3);
    resetDut();       checkIrq("rst_irq", 1'b0); checkRd("rst_rdata", 32'h0);
    rd(4'h0);         checkRd("rst_ctrl", 32'h0);
    rd(4'h4);         checkRd("rst_presc", 32'h0);
    rd(4'h8);         checkRd("rst_load", 32'h0);
    rd(4'hC);         checkRd("rst_count", 32'h0);
    idle(40);         checkIrq("rst_irq_late", 1'b0);
    rd(4'h0);         checkRd("rst_ctrl_late", 32'h0);

    // Randomized traffic, checked by the compare process every cycle.
    $display("[TB] random traffic");
    resetDut();
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      bit [3:0]    a;
      r = $urandom_range(0, 99);
      a = 4'($urandom);
      if (r < 40)       idle(1);
      else if (r < 65)  rd(a);
      else if (r < 76)  wr({2'd0, 2'($urandom)}, {28'($urandom), 4'($urandom)} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      else if (r < 82)  wr(4'h4, 32'($urandom_range(0, 3)));
      else if (r < 89)  wr(4'h8, 32'($urandom_range(0, 7)));
      else if (r < 92)  wr(4'hC, $urandom);
      else if (r < 94)  wr(a, $urandom);
      else if (r < 95)  resetDut();
      else              applyStimulus(1'b1, 1'b1, a, 32'($urandom_range(0, 15)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
